// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported main memory between the i-cache and d-cache.
// d has priority; a starvation counter forces an i grant after STARVE_MAX d grants.
module mem_arbiter #(
  parameter int ADDR_WIDTH       = 17,
  parameter int LEN              = 32,
  parameter int ENTRY_INDEX_SIZE = 3,
  parameter int BURST_BEATS      = 3,
  parameter int STARVE_MAX       = 4,
  parameter int TIMEOUT          = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  i_req,
  input  logic [ADDR_WIDTH-1:0]       i_addr,
  input  logic [1:0]                  d_req,
  input  logic [ADDR_WIDTH-1:0]       d_addr,
  input  logic [ENTRY_INDEX_SIZE-1:0] d_length,
  input  logic [LEN-1:0]              d_wdata,
  output logic [1:0]                  mem_signal,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [ENTRY_INDEX_SIZE-1:0] mem_length,
  output logic [LEN-1:0]              mem_wdata,
  input  logic [LEN-1:0]              mem_data,
  input  logic [1:0]                  mem_status,
  output logic [LEN-1:0]              rdata,
  output logic                        i_done,
  output logic                        d_done,
  output logic                        d_beat_valid,
  output logic [ENTRY_INDEX_SIZE-1:0] d_beat_idx,
  output logic                        timeout_err
);

  localparam logic [1:0] MEM_NOP        = 2'd0;
  localparam logic [1:0] MEM_READ       = 2'd1;
  localparam logic [1:0] MEM_WRITE      = 2'd2;
  localparam logic [1:0] MEM_READ_BURST = 2'd3;
  localparam logic [1:0] MEM_FINISHED   = 2'd2;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                      state_r, state_s;
  logic                        owner_d_r, owner_d_s;
  logic [1:0]                  cmd_r, cmd_s;
  logic [1:0]                  mem_signal_r, mem_signal_s;
  logic [ADDR_WIDTH-1:0]       mem_addr_r, mem_addr_s;
  logic [ENTRY_INDEX_SIZE-1:0] mem_length_r, mem_length_s;
  logic [LEN-1:0]              rdata_r, rdata_s;
  logic                        i_done_r, i_done_s;
  logic                        d_done_r, d_done_s;
  logic                        beat_valid_r, beat_valid_s;
  logic [ENTRY_INDEX_SIZE-1:0] beat_idx_r, beat_idx_s;
  logic                        timeout_err_r, timeout_err_s;
  logic [STV_W-1:0]            starve_r, starve_s;
  logic [CNT_W-1:0]            busy_cnt_r, busy_cnt_s;
  logic                        i_pend_s, d_pend_s, beat_cmd_s;
  logic [ENTRY_INDEX_SIZE-1:0] beat_last_s;

  assign i_pend_s    = (i_req != MEM_NOP);
  assign d_pend_s    = (d_req != MEM_NOP);
  assign beat_cmd_s  = (cmd_r == MEM_WRITE) || (cmd_r == MEM_READ_BURST);
  assign beat_last_s = (cmd_r == MEM_WRITE) ? (mem_length_r - ENTRY_INDEX_SIZE'(1'b1))
                                            : ENTRY_INDEX_SIZE'(BURST_BEATS - 1);

  // Next-state and next-register computation for the arbitration FSM.
  always_comb begin
    state_s       = state_r;
    owner_d_s     = owner_d_r;
    cmd_s         = cmd_r;
    mem_signal_s  = mem_signal_r;
    mem_addr_s    = mem_addr_r;
    mem_length_s  = mem_length_r;
    rdata_s       = rdata_r;
    i_done_s      = 1'b0;
    d_done_s      = 1'b0;
    beat_valid_s  = 1'b0;
    beat_idx_s    = beat_idx_r;
    timeout_err_s = timeout_err_r;
    starve_s      = i_pend_s ? starve_r : {STV_W{1'b0}};
    busy_cnt_s    = busy_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (d_pend_s && !(i_pend_s && (starve_r == STV_W'(STARVE_MAX)))) begin
          owner_d_s    = 1'b1;
          cmd_s        = d_req;
          mem_addr_s   = d_addr;
          mem_length_s = d_length;
          if (i_pend_s && (starve_r != STV_W'(STARVE_MAX))) begin
            starve_s = starve_r + STV_W'(1'b1);
          end else begin
            starve_s = starve_r;
          end
          // A zero-length write never touches memory.
          if ((d_req == MEM_WRITE) && (d_length == {ENTRY_INDEX_SIZE{1'b0}})) begin
            mem_signal_s = MEM_NOP;
            d_done_s     = 1'b1;
            state_s      = ST_DONE;
          end else begin
            mem_signal_s = d_req;
            state_s      = ST_ISSUE;
          end
        end else if (i_pend_s) begin
          owner_d_s    = 1'b0;
          cmd_s        = MEM_READ;
          mem_signal_s = MEM_READ;
          mem_addr_s   = i_addr;
          mem_length_s = {ENTRY_INDEX_SIZE{1'b0}};
          starve_s     = {STV_W{1'b0}};
          state_s      = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        busy_cnt_s   = {CNT_W{1'b0}};
        beat_valid_s = beat_cmd_s;
        beat_idx_s   = {ENTRY_INDEX_SIZE{1'b0}};
        state_s      = ST_BUSY;
      end
      ST_BUSY: begin
        busy_cnt_s = busy_cnt_r + CNT_W'(1'b1);
        if ((cmd_r == MEM_READ) || (cmd_r == MEM_READ_BURST)) begin
          rdata_s = mem_data;
        end else begin
          rdata_s = rdata_r;
        end
        if (mem_status == MEM_FINISHED) begin
          mem_signal_s = MEM_NOP;
          d_done_s     = owner_d_r;
          i_done_s     = !owner_d_r;
          state_s      = ST_DONE;
        end else if (busy_cnt_r == CNT_W'(TIMEOUT - 1)) begin
          mem_signal_s  = MEM_NOP;
          timeout_err_s = 1'b1;
          d_done_s      = owner_d_r;
          i_done_s      = !owner_d_r;
          beat_idx_s    = {ENTRY_INDEX_SIZE{1'b0}};
          state_s       = ST_IDLE;
        end else begin
          beat_valid_s = beat_cmd_s;
          if (beat_cmd_s && (beat_idx_r != beat_last_s)) begin
            beat_idx_s = beat_idx_r + ENTRY_INDEX_SIZE'(1'b1);
          end else begin
            beat_idx_s = beat_idx_r;
          end
        end
      end
      ST_DONE: begin
        beat_idx_s = {ENTRY_INDEX_SIZE{1'b0}};
        state_s    = ST_IDLE;
      end
      default: begin
        mem_signal_s = MEM_NOP;
        state_s      = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      owner_d_r     <= 1'b0;
      cmd_r         <= MEM_NOP;
      mem_signal_r  <= MEM_NOP;
      mem_addr_r    <= {ADDR_WIDTH{1'b0}};
      mem_length_r  <= {ENTRY_INDEX_SIZE{1'b0}};
      rdata_r       <= {LEN{1'b0}};
      i_done_r      <= 1'b0;
      d_done_r      <= 1'b0;
      beat_valid_r  <= 1'b0;
      beat_idx_r    <= {ENTRY_INDEX_SIZE{1'b0}};
      timeout_err_r <= 1'b0;
      starve_r      <= {STV_W{1'b0}};
      busy_cnt_r    <= {CNT_W{1'b0}};
    end else begin
      state_r       <= state_s;
      owner_d_r     <= owner_d_s;
      cmd_r         <= cmd_s;
      mem_signal_r  <= mem_signal_s;
      mem_addr_r    <= mem_addr_s;
      mem_length_r  <= mem_length_s;
      rdata_r       <= rdata_s;
      i_done_r      <= i_done_s;
      d_done_r      <= d_done_s;
      beat_valid_r  <= beat_valid_s;
      beat_idx_r    <= beat_idx_s;
      timeout_err_r <= timeout_err_s;
      starve_r      <= starve_s;
      busy_cnt_r    <= busy_cnt_s;
    end
  end

  assign mem_signal   = mem_signal_r;
  assign mem_addr     = mem_addr_r;
  assign mem_length   = mem_length_r;
  assign mem_wdata    = (owner_d_r && ((state_r == ST_ISSUE) || (state_r == ST_BUSY)))
                        ? d_wdata : {LEN{1'b0}};
  assign rdata        = rdata_r;
  assign i_done       = i_done_r;
  assign d_done       = d_done_r;
  assign d_beat_valid = beat_valid_r;
  assign d_beat_idx   = beat_idx_r;
  assign timeout_err  = timeout_err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural main-memory model.
module tb_mem_arbiter;
  localparam int AW = 17;
  localparam int LW = 32;
  localparam int IW = 3;
  localparam logic [1:0] NOP = 2'd0, RD = 2'd1, WR = 2'd2, BR = 2'd3;
  localparam logic [1:0] WORKING = 2'd1, FINISHED = 2'd2;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] i_req, d_req;
  logic [AW-1:0] i_addr, d_addr;
  logic [IW-1:0] d_length;
  logic [LW-1:0] d_wdata;
  logic [1:0] mem_signal;
  logic [AW-1:0] mem_addr;
  logic [IW-1:0] mem_length;
  logic [LW-1:0] mem_wdata, mem_data, rdata;
  logic [1:0] mem_status;
  logic i_done, d_done, d_beat_valid, timeout_err;
  logic [IW-1:0] d_beat_idx;

  int tests = 0;
  int fails = 0;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_addr(d_addr), .d_length(d_length), .d_wdata(d_wdata),
    .mem_signal(mem_signal), .mem_addr(mem_addr), .mem_length(mem_length),
    .mem_wdata(mem_wdata), .mem_data(mem_data), .mem_status(mem_status),
    .rdata(rdata), .i_done(i_done), .d_done(d_done),
    .d_beat_valid(d_beat_valid), .d_beat_idx(d_beat_idx), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Memory model: accepts a command when idle, finishes on the last beat.
  logic mbusy, stuck;
  logic [1:0] mcmd;
  logic [AW-1:0] maddr;
  int mtot, mrem;
  logic [LW-1:0] wlog [0:7];

  function automatic int nbeats(input logic [1:0] c, input logic [IW-1:0] l);
    if (c == RD) return 1;
    else if (c == BR) return 3;
    else if (l == 3'd1) return 2;
    else return int'(l);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mbusy <= 1'b0; mtot <= 0; mrem <= 0; mcmd <= NOP; maddr <= '0;
    end else if (!mbusy) begin
      if (mem_signal != NOP) begin
        mbusy <= 1'b1; mcmd <= mem_signal; maddr <= mem_addr;
        mtot <= nbeats(mem_signal, mem_length);
        mrem <= nbeats(mem_signal, mem_length);
      end
    end else begin
      if (mcmd == WR) wlog[3'(mtot - mrem)] <= mem_wdata;
      if (mem_signal == NOP) mbusy <= 1'b0;
      else if (stuck) mbusy <= 1'b1;
      else if (mrem == 1) mbusy <= 1'b0;
      else mrem <= mrem - 1;
    end
  end

  assign mem_status = !mbusy ? 2'd0 : ((!stuck && mrem == 1) ? FINISHED : WORKING);
  assign mem_data   = mbusy ? (32'hC0DE0000 | (32'(maddr) + 32'(mtot - mrem))) : 32'hDEADBEEF;
  assign d_wdata    = 32'h000000A0 + 32'(d_beat_idx);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts negedges until the selected done pulse is seen, bounded by budget.
  task automatic wait_for(input int sel_d, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((sel_d != 0) ? d_done : i_done) && n < budget);
  endtask

  initial begin
    int n, dcnt, bcnt, last_idx, extra;
    logic seen, glitch, got_i;
    rst = 1'b1; stuck = 1'b0;
    i_req = NOP; d_req = NOP; i_addr = '0; d_addr = '0; d_length = '0;
    #1;
    chk("rst_sig", 32'(mem_signal), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_len", 32'(mem_length), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_pulses", {28'd0, i_done, d_done, d_beat_valid, timeout_err}, 32'd0);
    chk("rst_idx", 32'(d_beat_idx), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single i READ
    i_req = RD; i_addr = 17'h00100;
    @(negedge clk);
    chk("t1_sig_c1", 32'(mem_signal), 32'(RD));
    chk("t1_addr", 32'(mem_addr), 32'h100);
    @(negedge clk);
    @(negedge clk);
    chk("t1_idone_c3", 32'(i_done), 32'd1);
    chk("t1_rdata", rdata, 32'hC0DE0100);
    chk("t1_sig_nop", 32'(mem_signal), 32'(NOP));
    i_req = NOP;
    @(negedge clk);
    chk("t1_idone_drop", 32'(i_done), 32'd0);

    // Illegal i command becomes READ
    i_req = WR; i_addr = 17'h00104;
    @(negedge clk);
    chk("t1b_conv", 32'(mem_signal), 32'(RD));
    wait_for(0, 10, n);
    chk("t1b_lat", 32'(n), 32'd2);
    chk("t1b_rdata", rdata, 32'hC0DE0104);
    i_req = NOP;
    @(negedge clk);

    // Simultaneous i and d READ: d first
    i_req = RD; i_addr = 17'h00100; d_req = RD; d_addr = 17'h00080;
    wait_for(1, 10, n);
    chk("t2_d_lat", 32'(n), 32'd3);
    chk("t2_i_not_yet", 32'(i_done), 32'd0);
    chk("t2_d_rdata", rdata, 32'hC0DE0080);
    d_req = NOP;
    wait_for(0, 10, n);
    chk("t2_i_gap", 32'(n), 32'd4);
    chk("t2_i_rdata", rdata, 32'hC0DE0100);
    i_req = NOP;
    @(negedge clk);

    // Zero-length write completes without a memory access
    d_req = WR; d_length = 3'd0; d_addr = 17'h00040;
    @(negedge clk);
    chk("t3_ddone", 32'(d_done), 32'd1);
    chk("t3_sig", 32'(mem_signal), 32'(NOP));
    d_req = NOP;
    @(negedge clk);

    // Four-beat write
    d_req = WR; d_length = 3'd4; d_addr = 17'h00040;
    seen = 1'b0; glitch = 1'b0; bcnt = 0; dcnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_signal == WR) seen = 1'b1;
      if (seen && mem_signal == NOP && !d_done) glitch = 1'b1;
      if (d_beat_valid) begin
        chk("t4_beat_idx", 32'(d_beat_idx), 32'(bcnt));
        bcnt++;
      end
      if (d_done) begin
        dcnt++;
        d_req = NOP;
        break;
      end
    end
    extra = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (d_done) extra++;
    end
    chk("t4_beats", 32'(bcnt), 32'd4);
    chk("t4_glitch", 32'(glitch), 32'd0);
    chk("t4_done_once", 32'(dcnt + extra), 32'd1);
    chk("t4_len", 32'(mem_length), 32'd4);
    chk("t4_w0", wlog[0], 32'hA0);
    chk("t4_w1", wlog[1], 32'hA1);
    chk("t4_w2", wlog[2], 32'hA2);
    chk("t4_w3", wlog[3], 32'hA3);

    // Continuous d bursts vs pending i READ
    d_req = BR; d_addr = 17'h00200; i_req = RD; i_addr = 17'h00100;
    dcnt = 0; last_idx = -1; got_i = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (d_beat_valid) last_idx = int'(d_beat_idx);
      if (d_done) begin
        dcnt++;
        if (dcnt == 1) begin
          chk("t5_burst_rdata", rdata, 32'hC0DE0202);
          chk("t5_last_idx", 32'(last_idx), 32'd2);
        end
      end
      if (i_done) begin
        got_i = 1'b1;
        chk("t5_i_rdata", rdata, 32'hC0DE0100);
        break;
      end
    end
    i_req = NOP; d_req = NOP;
    chk("t5_i_granted", 32'(got_i), 32'd1);
    chk("t5_d_grants", 32'(dcnt), 32'd4);
    @(negedge clk); @(negedge clk);

    // Memory stuck: timeout abort
    stuck = 1'b1;
    d_req = RD; d_addr = 17'h00300;
    wait_for(1, 100, n);
    chk("t6_lat", 32'(n), 32'd66);
    chk("t6_err", 32'(timeout_err), 32'd1);
    chk("t6_sig", 32'(mem_signal), 32'(NOP));
    d_req = NOP; stuck = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("t6_sticky", 32'(timeout_err), 32'd1);
    chk("t6_done_drop", 32'(d_done), 32'd0);

    // Reset mid-burst, then a pending i READ completes
    d_req = BR; d_addr = 17'h00200; i_req = RD; i_addr = 17'h00100;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (d_beat_valid) break;
    end
    chk("t7_in_burst", 32'(d_beat_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t7_sig", 32'(mem_signal), 32'(NOP));
    chk("t7_pulses", {28'd0, i_done, d_done, d_beat_valid, timeout_err}, 32'd0);
    chk("t7_idx", 32'(d_beat_idx), 32'd0);
    d_req = NOP;
    @(negedge clk);
    rst = 1'b0;
    wait_for(0, 10, n);
    chk("t7_i_lat", 32'(n), 32'd3);
    chk("t7_i_rdata", rdata, 32'hC0DE0100);
    i_req = NOP;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits between the instruction cache, the data cache and the single-ported main memory.
- Accepts one outstanding request from each cache and grants the memory to one requester at a time.
- Holds the grant for the full duration of multi-beat writes and burst reads, and returns completion/beat strobes to the owner.
- Data cache has priority; a starvation counter guarantees the instruction cache forward progress.

Parameters:
ADDR_WIDTH, 17, byte address width
LEN, 32, data word width
ENTRY_INDEX_SIZE, 3, width of write length / beat index
BURST_BEATS, 3, beats returned by a burst read (memory-fixed)
STARVE_MAX, 4, consecutive d-grants allowed while i-request pending
TIMEOUT, 64, max cycles in BUSY before abort

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
i_req  in  2  i-cache command (shared defines encodings: MEM_NOP/READ/WRITE/READ_BURST)
i_addr  in  ADDR_WIDTH  i-cache address
d_req  in  2  d-cache command
d_addr  in  ADDR_WIDTH  d-cache address
d_length  in  ENTRY_INDEX_SIZE  write beat count
d_wdata  in  LEN  write data (d-cache updates per beat)
mem_signal  out  2  command to memory
mem_addr  out  ADDR_WIDTH  address to memory
mem_length  out  ENTRY_INDEX_SIZE  write length to memory
mem_wdata  out  LEN  write data to memory (combinational pass of d_wdata while d owns)
mem_data  in  LEN  memory read data
mem_status  in  2  memory status (MEM_FINISHED / MEM_DATA_WORKING)
rdata  out  LEN  registered copy of mem_data for the owner
i_done  out  1  one-cycle completion pulse to i-cache
d_done  out  1  one-cycle completion pulse to d-cache
d_beat_valid  out  1  pulse per valid write/burst beat
d_beat_idx  out  ENTRY_INDEX_SIZE  index of current beat
timeout_err  out  1  sticky abort flag, cleared by rst only

Behaviour:
- Reset (async, immediate): state IDLE; mem_signal=MEM_NOP; mem_addr, mem_length, rdata, d_beat_idx=0; all pulses and timeout_err=0; starve_cnt=0.
- Requests are level-held by the requester until its done pulse; a request dropped early is ignored after grant.
- States: IDLE, ISSUE, BUSY, DONE.
- IDLE:
  - If a request is pending, choose the owner and register mem_signal/addr/length; go ISSUE.
  - Default choice is d; i wins if i pending and starve_cnt==STARVE_MAX.
  - Only d pending: d. Only i pending: i.
- ISSUE: memory samples the command at this edge; mem_status is stale and ignored; go BUSY; cycle counter=0.
- BUSY, each cycle:
  - For READ / READ_BURST: rdata<=mem_data.
  - For WRITE / READ_BURST: d_beat_valid pulses and d_beat_idx increments.
  - When mem_status==MEM_FINISHED: mem_signal<=MEM_NOP; go DONE.
  - On the final beat d_beat_idx equals length-1 (WRITE) or BURST_BEATS-1 (burst).
- DONE: owner's done pulse high exactly one cycle; d_beat_idx<=0; go IDLE. Next grant is decided in that IDLE cycle, so back-to-back grants are separated by one cycle.
- Single READ latency: request in IDLE -> done 3 cycles later.
- starve_cnt:
  - +1 on each d grant while i pending; saturates at STARVE_MAX.
  - Cleared on each i grant or when i not pending.
- WRITE with d_length==0: no memory access; go directly to DONE (d_done next cycle).
- WRITE with d_length==1 is treated as length 2 by memory; the arbiter forwards unchanged; d-cache must not issue it.
- i-cache requests other than MEM_READ are illegal: converted to MEM_READ.
- Timeout: BUSY counter reaching TIMEOUT -> mem_signal=MEM_NOP, timeout_err=1, owner's done pulses, go IDLE.
- Simultaneous new request from the current owner during DONE is seen as a new request in IDLE.

Test Plan:
- i_req=READ, addr 0x100, d idle -> mem_signal=READ at cycle 1, rdata=storage word, i_done pulses cycle 3, mem_signal back to NOP.
- i READ and d READ asserted same cycle -> d granted first, d_done, then i granted; i_done 4 cycles after d_done.
- d WRITE length 4, data 0xA0..0xA3 per beat -> d_beat_valid pulses with idx 0..3, one d_done, mem_signal never glitches to NOP mid-write.
- d issues READ_BURST continuously while i READ pending -> i granted after exactly STARVE_MAX=4 d grants.
- Memory model stuck at MEM_DATA_WORKING -> after 64 BUSY cycles timeout_err=1, owner done pulses, mem_signal=NOP.
- rst asserted mid-burst -> same cycle mem_signal=NOP, pulses 0; after release a pending i READ completes normally.
